// File: rtl/caf_ctrl_pkg.sv
// Shared definitions for the CAF lag-sweep controller.
// Contents: FSM state encoding, clog2 helper for counter widths,
// and a legality check for the sweep/address parameters.
package caf_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // Smallest b with 2**b >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    result = 32'sd0;
    for (int b = 0; b < 31; b++) begin
      if ((32'sd1 << b) < value) result = b + 32'sd1;
    end
    return result;
  endfunction

  // Every lag's last read must fit the RAM, and the lag index must hold num_lags-1.
  function automatic bit params_ok(input int length, input int num_lags,
                                   input int addr_bits, input int lag_bits);
    return (length >= 32'sd1) && (num_lags >= 32'sd1) &&
           ((length + num_lags - 32'sd1) <= (32'sd1 << addr_bits)) &&
           ((32'sd1 << lag_bits) >= num_lags);
  endfunction

endpackage

// File: rtl/dot_prod_lag_ctrl_if.sv
// Bus bundle between the lag-sweep controller, the sample RAMs / dot-product
// pipeline, and the result consumer.
//   master: controller side (drives RAM reads, samples valid, result port)
//   slave : environment side (RAMs, dot_prod_pip, result sink)
interface dot_prod_lag_ctrl_if #(
  parameter int addr_bits = 8,
  parameter int lag_bits  = 3,
  parameter int i_bits    = 24,
  parameter int q_bits    = 24
);
  logic                 rd_en;
  logic [addr_bits-1:0] ref_addr;
  logic [addr_bits-1:0] rx_addr;
  logic                 dp_samples_tvalid;
  logic                 dp_product_tready;
  logic                 dp_product_tvalid;
  logic [i_bits-1:0]    dp_i;
  logic [q_bits-1:0]    dp_q;
  logic                 out_tvalid;
  logic                 out_tready;
  logic [i_bits-1:0]    out_i;
  logic [q_bits-1:0]    out_q;
  logic [lag_bits-1:0]  out_lag;

  modport master (
    output rd_en, ref_addr, rx_addr, dp_samples_tvalid, dp_product_tready,
    input  dp_product_tvalid, dp_i, dp_q,
    output out_tvalid, out_i, out_q, out_lag,
    input  out_tready
  );

  modport slave (
    input  rd_en, ref_addr, rx_addr, dp_samples_tvalid, dp_product_tready,
    output dp_product_tvalid, dp_i, dp_q,
    input  out_tvalid, out_i, out_q, out_lag,
    output out_tready
  );
endinterface

// File: rtl/dot_prod_addr_gen.sv
// Sample index / lag counters and RAM address generation.
// Ports: clk, reset (sync, active-high); i_clr zeroes n and lag; i_step
// advances n (wrapping after length-1); i_next_lag advances lag;
// i_feed_nxt is the next-cycle read strobe. Outputs rd_en, ref_addr = n,
// rx_addr = n + lag (mod 2**addr_bits), current lag, last_n / last_lag flags.
module dot_prod_addr_gen
  import caf_ctrl_pkg::*;
#(
  parameter int length    = 5,
  parameter int num_lags  = 4,
  parameter int addr_bits = 8,
  parameter int lag_bits  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clr,
  input  logic                 i_step,
  input  logic                 i_next_lag,
  input  logic                 i_feed_nxt,
  output logic                 o_rd_en,
  output logic [addr_bits-1:0] o_ref_addr,
  output logic [addr_bits-1:0] o_rx_addr,
  output logic [lag_bits-1:0]  o_lag,
  output logic                 o_last_n,
  output logic                 o_last_lag
);
  localparam int n_bits = (length > 32'sd1) ? clog2(length) : 32'sd1;
  localparam logic [n_bits-1:0]   n_last   = n_bits'(length - 32'sd1);
  localparam logic [lag_bits-1:0] lag_last = lag_bits'(num_lags - 32'sd1);

  logic [n_bits-1:0]   r_n;
  logic [lag_bits-1:0] r_lag;
  logic                r_rd_en;

  // n / lag counters and the registered read strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      r_n     <= '0;
      r_lag   <= '0;
      r_rd_en <= 1'b0;
    end else begin
      r_rd_en <= i_feed_nxt;
      if (i_clr) begin
        r_n   <= '0;
        r_lag <= '0;
      end else begin
        // n returns to 0 after the last read so the next lag starts clean
        if (i_step) r_n <= o_last_n ? '0 : (r_n + n_bits'(1));
        if (i_next_lag) r_lag <= r_lag + lag_bits'(1);
      end
    end
  end

  assign o_last_n   = (r_n == n_last);
  assign o_last_lag = (r_lag == lag_last);
  assign o_rd_en    = r_rd_en;
  assign o_lag      = r_lag;
  assign o_ref_addr = addr_bits'(r_n);
  assign o_rx_addr  = addr_bits'(r_n) + addr_bits'(r_lag);

endmodule

// File: rtl/dot_prod_lag_ctrl.sv
// Lag-sweep sequencer for dot_prod_pip in the CAF path.
// Ports: clk, reset (sync, active-high); start (sampled in IDLE);
// busy / done (1-cycle pulse) / err (sticky stray-result flag);
// bus (master): RAM reads, samples valid, product ready/valid/data,
// and the backpressured per-lag result port out_*.
module dot_prod_lag_ctrl
  import caf_ctrl_pkg::*;
#(
  parameter int length    = 5,
  parameter int num_lags  = 4,
  parameter int addr_bits = 8,
  parameter int lag_bits  = 3,
  parameter int i_bits    = 24,
  parameter int q_bits    = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  output logic err,
  dot_prod_lag_ctrl_if.master bus
);
  if (!params_ok(length, num_lags, addr_bits, lag_bits)) begin : g_param_check
    $error("dot_prod_lag_ctrl: illegal length/num_lags/addr_bits/lag_bits");
  end

  state_t              r_state, w_state_nxt;
  logic                w_clr, w_step, w_next_lag, w_capture, w_accept, w_done_nxt, w_stray;
  logic                w_rd_en, w_last_n, w_last_lag;
  logic [lag_bits-1:0] w_lag;
  logic                r_done, r_err, r_samples_tvalid, r_product_tready, r_out_tvalid;
  logic [i_bits-1:0]   r_out_i;
  logic [q_bits-1:0]   r_out_q;
  logic [lag_bits-1:0] r_out_lag;

  dot_prod_addr_gen #(
    .length(length), .num_lags(num_lags), .addr_bits(addr_bits), .lag_bits(lag_bits)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_clr),
    .i_step     (w_step),
    .i_next_lag (w_next_lag),
    .i_feed_nxt (w_state_nxt == ST_FEED),
    .o_rd_en    (w_rd_en),
    .o_ref_addr (bus.ref_addr),
    .o_rx_addr  (bus.rx_addr),
    .o_lag      (w_lag),
    .o_last_n   (w_last_n),
    .o_last_lag (w_last_lag)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state and per-cycle control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_step      = 1'b0;
    w_next_lag  = 1'b0;
    w_capture   = 1'b0;
    w_accept    = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_clr       = 1'b1;
          w_state_nxt = ST_FEED;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FEED: begin
        w_step = 1'b1;
        if (w_last_n) w_state_nxt = ST_DRAIN;
        else          w_state_nxt = ST_FEED;
      end
      ST_DRAIN: begin
        if (bus.dp_product_tvalid) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (r_out_tvalid && bus.out_tready) begin
          w_accept = 1'b1;
          if (w_last_lag) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_next_lag  = 1'b1;
            w_state_nxt = ST_FEED;
          end
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // a result outside DRAIN has no lag to belong to
    w_stray = bus.dp_product_tvalid && r_product_tready && (r_state != ST_DRAIN);
  end

  // status, sample-valid alignment and held result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done           <= 1'b0;
      r_err            <= 1'b0;
      r_samples_tvalid <= 1'b0;
      r_product_tready <= 1'b0;
      r_out_tvalid     <= 1'b0;
      r_out_i          <= '0;
      r_out_q          <= '0;
      r_out_lag        <= '0;
    end else begin
      r_product_tready <= 1'b1;
      // RAM data arrives one cycle after the read strobe
      r_samples_tvalid <= w_rd_en;
      r_done           <= w_done_nxt;
      // a stray result in the same cycle as start still counts
      if (w_stray)    r_err <= 1'b1;
      else if (w_clr) r_err <= 1'b0;
      if (w_capture) begin
        r_out_tvalid <= 1'b1;
        r_out_i      <= bus.dp_i;
        r_out_q      <= bus.dp_q;
        r_out_lag    <= w_lag;
      end else if (w_accept) begin
        r_out_tvalid <= 1'b0;
      end
    end
  end

  assign busy                  = (r_state != ST_IDLE);
  assign done                  = r_done;
  assign err                   = r_err;
  assign bus.rd_en             = w_rd_en;
  assign bus.dp_samples_tvalid = r_samples_tvalid;
  assign bus.dp_product_tready = r_product_tready;
  assign bus.out_tvalid        = r_out_tvalid;
  assign bus.out_i             = r_out_i;
  assign bus.out_q             = r_out_q;
  assign bus.out_lag           = r_out_lag;

endmodule

// File: tb/tb_dot_prod_lag_ctrl.sv
// Self-checking bench for dot_prod_lag_ctrl: length=5, num_lags=3.
// Environment: ref RAM = 1+0j, rx RAM[m] = m + j*2m, a dot-product model
// with 3 cycles of output latency. Lag L gives i = 10+5L, q = 2*(10+5L).
module tb_dot_prod_lag_ctrl;
  localparam int LEN = 5, LAGS = 3, AB = 8, LB = 3, IB = 24, QB = 24, PL = 3;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, inj = 1'b0;
  logic busy, done, err;

  dot_prod_lag_ctrl_if #(.addr_bits(AB), .lag_bits(LB), .i_bits(IB), .q_bits(QB)) bus ();

  dot_prod_lag_ctrl #(
    .length(LEN), .num_lags(LAGS), .addr_bits(AB), .lag_bits(LB), .i_bits(IB), .q_bits(QB)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err), .bus(bus)
  );

  always #5 clk = ~clk;

  // ---------------- environment: sample RAMs and dot-product model ----------
  logic [IB-1:0] d_ref, d_rx_i, d_rx_q, acc_i, acc_q;
  logic [IB-1:0] p_i [PL];
  logic [QB-1:0] p_q [PL];
  logic          p_v [PL];
  int            cnt;

  assign bus.dp_product_tvalid = p_v[PL-1] | inj;
  assign bus.dp_i              = p_i[PL-1];
  assign bus.dp_q              = p_q[PL-1];

  always @(posedge clk) begin
    if (bus.rd_en) begin
      d_ref  <= 24'd1;
      d_rx_i <= IB'(bus.rx_addr);
      d_rx_q <= IB'(bus.rx_addr) << 1;
    end
    if (reset) begin
      acc_i <= '0; acc_q <= '0; cnt <= 0;
      for (int k = 0; k < PL; k++) p_v[k] <= 1'b0;
    end else begin
      p_v[0] <= 1'b0;
      if (bus.dp_samples_tvalid) begin
        if (cnt == LEN - 1) begin
          p_v[0] <= 1'b1;
          p_i[0] <= acc_i + d_ref * d_rx_i;
          p_q[0] <= acc_q + d_ref * d_rx_q;
          acc_i  <= '0; acc_q <= '0; cnt <= 0;
        end else begin
          acc_i <= acc_i + d_ref * d_rx_i;
          acc_q <= acc_q + d_ref * d_rx_q;
          cnt   <= cnt + 1;
        end
      end
      for (int k = 1; k < PL; k++) begin
        p_v[k] <= p_v[k-1]; p_i[k] <= p_i[k-1]; p_q[k] <= p_q[k-1];
      end
    end
  end

  // ---------------- monitor: alignment, handshakes, done pulses -------------
  logic prev_rd = 1'b0, prev_rst = 1'b1;
  int   misalign = 0, hs_cnt = 0, done_cnt = 0;

  always @(posedge clk) begin
    prev_rd  <= bus.rd_en;
    prev_rst <= reset;
    if (!reset && !prev_rst && (bus.dp_samples_tvalid !== prev_rd)) misalign <= misalign + 1;
    if (!reset && bus.out_tvalid && bus.out_tready) hs_cnt <= hs_cnt + 1;
    if (!reset && done) done_cnt <= done_cnt + 1;
  end

  // ---------------- checking helpers ----------------------------------------
  int n_checks = 0, n_errors = 0;
  int hs_base = 0, done_base = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int            hold;       // cycles out_tready stays low after out_tvalid
    bit            poke_start; // pulse start during FEED (must be ignored)
    logic [IB-1:0] exp_i;
    logic [QB-1:0] exp_q;
    logic [LB-1:0] exp_lag;
  } vec_t;

  vec_t tab[9];

  // One lag: FEED address check, result capture, optional hold, handshake.
  task automatic do_result(input vec_t v);
    bit addr_ok, stable;
    int to, exp_rx;
    if (v.exp_lag == 3'd0) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      hs_base   = hs_cnt;
      done_base = done_cnt;
    end
    bus.out_tready = (v.hold == 0);
    addr_ok = 1'b1;
    for (int c = 0; c < LEN; c++) begin
      exp_rx = c + int'(v.exp_lag);
      if (bus.rd_en !== 1'b1 || int'(bus.ref_addr) != c || int'(bus.rx_addr) != exp_rx)
        addr_ok = 1'b0;
      start = (v.poke_start && c == 1);
      tick();
    end
    start = 1'b0;
    chk("feed_addr_seq", addr_ok, 1);
    chk("rd_en_after_feed", bus.rd_en, 0);
    to = 0;
    while (bus.out_tvalid !== 1'b1 && to < 30) begin
      tick();
      to++;
    end
    chk("result_wait_bound", (to < 30), 1);
    chk("out_i", bus.out_i, v.exp_i);
    chk("out_q", bus.out_q, v.exp_q);
    chk("out_lag", bus.out_lag, v.exp_lag);
    chk("busy_in_hold", busy, 1);
    if (v.hold > 0) begin
      stable = 1'b1;
      for (int h = 0; h < v.hold; h++) begin
        tick();
        if (bus.out_tvalid !== 1'b1 || bus.out_i !== v.exp_i || bus.out_q !== v.exp_q ||
            bus.out_lag !== v.exp_lag || bus.rd_en !== 1'b0)
          stable = 1'b0;
      end
      chk("hold_stable", stable, 1);
      bus.out_tready = 1'b1;
    end
    tick();
    if (v.exp_lag == 3'(LAGS - 1)) begin
      chk("done_pulse", done, 1);
      chk("busy_after_last", busy, 0);
      chk("out_tvalid_after_last", bus.out_tvalid, 0);
      tick();
      chk("done_one_cycle", done, 0);
      chk("err_clean_sweep", err, 0);
      chk("results_per_sweep", hs_cnt - hs_base, LAGS);
      chk("done_per_sweep", done_cnt - done_base, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // sweep 1: free-flowing; sweep 2: 10-cycle backpressure; sweep 3: start poked in FEED
    tab[0] = '{0,  1'b0, 24'd10, 24'd20, 3'd0};
    tab[1] = '{0,  1'b0, 24'd15, 24'd30, 3'd1};
    tab[2] = '{0,  1'b0, 24'd20, 24'd40, 3'd2};
    tab[3] = '{10, 1'b0, 24'd10, 24'd20, 3'd0};
    tab[4] = '{10, 1'b0, 24'd15, 24'd30, 3'd1};
    tab[5] = '{10, 1'b0, 24'd20, 24'd40, 3'd2};
    tab[6] = '{0,  1'b1, 24'd10, 24'd20, 3'd0};
    tab[7] = '{0,  1'b0, 24'd15, 24'd30, 3'd1};
    tab[8] = '{0,  1'b0, 24'd20, 24'd40, 3'd2};

    bus.out_tready = 1'b1;
    repeat (3) tick();
    chk("rst_product_tready", bus.dp_product_tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_samples_tvalid", bus.dp_samples_tvalid, 0);
    chk("rst_out_tvalid", bus.out_tvalid, 0);
    chk("rst_ref_addr", bus.ref_addr, 0);
    chk("rst_rx_addr", bus.rx_addr, 0);
    chk("rst_out_i", bus.out_i, 0);
    chk("rst_out_q", bus.out_q, 0);
    chk("rst_out_lag", bus.out_lag, 0);
    reset = 1'b0;
    tick();
    chk("product_tready_after_rst", bus.dp_product_tready, 1);

    for (int r = 0; r < 9; r++) do_result(tab[r]);

    // stray product in IDLE
    tick();
    inj = 1'b1;
    tick();
    inj = 1'b0;
    chk("stray_sets_err", err, 1);
    chk("stray_no_out_tvalid", bus.out_tvalid, 0);
    tick();
    chk("err_sticky", err, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_clears_err", err, 0);

    // finish lag 0, then reset two cycles into lag 1 FEED
    bus.out_tready = 1'b1;
    begin
      int to;
      to = 0;
      while (bus.out_tvalid !== 1'b1 && to < 40) begin
        tick();
        to++;
      end
      chk("lag0_wait_bound", (to < 40), 1);
    end
    tick();
    chk("lag1_feed_rd_en", bus.rd_en, 1);
    chk("lag1_feed_rx_addr", bus.rx_addr, 1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_rd_en", bus.rd_en, 0);
    chk("midrst_out_tvalid", bus.out_tvalid, 0);
    chk("midrst_ref_addr", bus.ref_addr, 0);
    chk("midrst_rx_addr", bus.rx_addr, 0);
    chk("midrst_out_i", bus.out_i, 0);
    chk("midrst_out_lag", bus.out_lag, 0);
    chk("midrst_product_tready", bus.dp_product_tready, 0);
    reset = 1'b0;
    tick();
    for (int r = 0; r < 3; r++) do_result(tab[r]);

    chk("samples_tvalid_alignment", misalign, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
